risc_spm_control_unit: RTL and testbench
========================================

// Module: risc_spm_control_unit
// PURPOSE
//  Control FSM for the RISC-SPM Processing_Unit datapath. Reads the IR contents and the Z flag.
//  Drives every register load, PC increment/load, both bus-mux selects and memory write.
//  Sequences fetch, decode, execute, memory read/write and branch.
//  Instruction = {opcode[7:4], src[3:2], dest[1:0]}.
// PARAMETERS
//  word_size   8  instruction width
//  op_size     4  opcode width
//  state_size  4  state register width
//  Sel1_size   3  Bus_1 mux select width
//  Sel2_size   2  Bus_2 mux select width
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous, active-low reset
//  instruction    in   word_size  IR contents
//  Zflag          in   1          registered ALU zero flag
//  Load_R0..R3    out  1 each     load general register Rn from Bus_2
//  Load_PC        out  1          load PC from Bus_2
//  Inc_PC         out  1          PC <= PC+1
//  Sel_Bus_1_Mux  out  Sel1_size  0..3 = R0..R3, 4 = PC
//  Sel_Bus_2_Mux  out  Sel2_size  0 = alu_out, 1 = Bus_1, 2 = mem_word
//  Load_IR        out  1          load IR from Bus_2
//  Load_Add_R     out  1          load address register
//  Load_Reg_Y     out  1          load Y operand register
//  Load_Reg_Z     out  1          capture ALU zero flag
//  write          out  1          memory write of Bus_1 at address
//  halted         out  1          high while in S_halt
// BEHAVIOUR
//  Structure and reset
//  - State register only; all outputs combinational from state, opcode, src, dest and Zflag.
//  - rst low: state <= S_idle immediately, including mid-instruction.
//  - In S_idle every output is 0, selects included.
//  - In any state, outputs not listed below are 0 and selects not listed are 0.
//  - Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8, HALT F.
//  - Codes 9..E are illegal and decode as HALT.
//  Fetch and decode
//  - S_idle : no outputs -> S_fet1.
//  - S_fet1 : Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_fet2.
//  - S_fet2 : Sel2=mem, Load_IR, Inc_PC -> S_dec.
//  - S_dec, NOP : no outputs -> S_fet1.
//  - S_dec, ADD/SUB/AND : Sel1=src, Sel2=Bus_1, Load_Reg_Y -> S_ex1.
//  - S_dec, NOT : Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest] -> S_fet1.
//  - S_dec, RD/WR : Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_rd1 / S_wr1.
//  - S_dec, BR : as RD -> S_br1.
//  - S_dec, BRZ, Zflag=1 : as BR -> S_br1.
//  - S_dec, BRZ, Zflag=0 : Inc_PC only (skip operand byte) -> S_fet1.
//  - S_dec, HALT/illegal : -> S_halt.
//  Execute, memory and branch
//  - S_ex1 : Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest] -> S_fet1.
//  - S_rd1/S_wr1 : Sel2=mem, Load_Add_R, Inc_PC -> S_rd2/S_wr2.
//  - S_rd2 : Sel2=mem, Load_R[dest] -> S_fet1.
//  - S_wr2 : Sel1=src, write -> S_fet1.
//  - S_br1 : Sel2=mem, Load_Add_R -> S_br2.
//  - S_br2 : Sel2=mem, Load_PC -> S_fet1.
//  - S_halt : all strobes 0, halted=1; held until rst asserted.
//  Latencies (cycles from S_fet1)
//  - NOP 3; NOT 3; ALU ops 4; RD/WR/BR 5; BRZ taken 5; BRZ not taken 3.
//  Invariants
//  - At most one Load_Rn asserted per cycle.
//  - Load_PC and Inc_PC are never asserted together.
//  - write is asserted only in S_wr2.
//  - No unreachable state may lock up: unused encodings -> S_idle on next clock.
// TESTING
//  - Reset: rst=0 mid S_ex1 -> S_idle at once, all outputs 0.
//  - Reset release: first edge -> S_fet1, Sel1=4, Load_Add_R=1.
//  - ADD: instruction=8'h1B (ADD R2,R3) -> S_dec Sel1=2, Load_Reg_Y=1;
//    S_ex1 Sel1=3, Sel2=0, Load_R3=1, Load_Reg_Z=1; back to S_fet1 after 4 cycles.
//  - RD: 8'h52 -> Load_Add_R in dec/rd1, Inc_PC in rd1; rd2 Sel2=2, Load_R2=1.
//  - WR: 8'h6C -> wr2 write=1, Sel1=3.
//  - BRZ: 8'h80 with Zflag=0 -> Inc_PC in S_dec, back to fetch after 3 cycles.
//  - BRZ: 8'h80 with Zflag=1 -> br2 Load_PC=1, Sel2=2.
//  - HALT/illegal: 8'hF0 -> halted=1, outputs frozen for 20 cycles.
//  - HALT/illegal: 8'hA0 -> halted=1.
//  - Every cycle: Load_PC&Inc_PC==0 and Load_R0..R3 onehot0 (assertions).

Source files
------------

// File: rtl/risc_spm_control_unit.sv
`timescale 1ns/1ps
// Control FSM for the RISC-SPM processing unit: sequences fetch, decode, execute,
// memory and branch steps and drives the datapath strobes from state and IR.
//
// state  | meaning
// S_idle | after reset, no strobes
// S_fet1 | PC -> address register
// S_fet2 | memory -> IR, PC+1
// S_dec  | decode; first step of every instruction
// S_ex1  | ALU result -> dest, capture Z
// S_rd1  | operand address byte -> address register (RD)
// S_rd2  | memory -> dest
// S_wr1  | operand address byte -> address register (WR)
// S_wr2  | src -> memory
// S_br1  | target address byte location -> address register
// S_br2  | memory -> PC
// S_halt | stopped until reset
module risc_spm_control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 Zflag,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 write,
  output logic                 halted
);

  typedef enum logic [state_size-1:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = 4'h0;
  localparam logic [op_size-1:0] OP_ADD = 4'h1;
  localparam logic [op_size-1:0] OP_SUB = 4'h2;
  localparam logic [op_size-1:0] OP_AND = 4'h3;
  localparam logic [op_size-1:0] OP_NOT = 4'h4;
  localparam logic [op_size-1:0] OP_RD  = 4'h5;
  localparam logic [op_size-1:0] OP_WR  = 4'h6;
  localparam logic [op_size-1:0] OP_BR  = 4'h7;
  localparam logic [op_size-1:0] OP_BRZ = 4'h8;

  localparam logic [Sel1_size-1:0] SEL1_PC   = 3'd4;
  localparam logic [Sel2_size-1:0] SEL2_ALU  = 2'd0;
  localparam logic [Sel2_size-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [Sel2_size-1:0] SEL2_MEM  = 2'd2;

  state_t state;
  state_t next_state;

  logic [op_size-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;
  logic [3:0]         load_r;
  logic [3:0]         dest_onehot;

  assign opcode      = instruction[word_size-1 -: op_size];
  assign src         = instruction[3:2];
  assign dest        = instruction[1:0];
  assign dest_onehot = 4'b0001 << dest;

  assign Load_R0 = load_r[0];
  assign Load_R1 = load_r[1];
  assign Load_R2 = load_r[2];
  assign Load_R3 = load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_idle;
    else      state <= next_state;
  end

  // Outputs are Mealy in S_dec: they depend on the opcode and, for BRZ, on Zflag.
  always_comb begin
    next_state    = S_idle;
    load_r        = 4'b0000;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;

    case (state)
      S_idle: next_state = S_fet1;

      S_fet1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_BUS1;
        Load_Add_R    = 1'b1;
        next_state    = S_fet2;
      end

      S_fet2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        next_state    = S_dec;
      end

      S_dec: begin
        case (opcode)
          OP_NOP: next_state = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            next_state    = S_ex1;
          end
          OP_NOT: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            load_r        = dest_onehot;
            next_state    = S_fet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            Sel_Bus_1_Mux = SEL1_PC;
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Add_R    = 1'b1;
            if (opcode == OP_RD)      next_state = S_rd1;
            else if (opcode == OP_WR) next_state = S_wr1;
            else                      next_state = S_br1;
          end
          OP_BRZ: begin
            if (Zflag) begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Add_R    = 1'b1;
              next_state    = S_br1;
            end else begin
              // Not taken: step PC past the target byte.
              Inc_PC     = 1'b1;
              next_state = S_fet1;
            end
          end
          default: next_state = S_halt;
        endcase
      end

      S_ex1: begin
        Sel_Bus_1_Mux = Sel1_size'(dest);
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        load_r        = dest_onehot;
        next_state    = S_fet1;
      end

      S_rd1, S_wr1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        next_state    = (state == S_rd1) ? S_rd2 : S_wr2;
      end

      S_rd2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        load_r        = dest_onehot;
        next_state    = S_fet1;
      end

      S_wr2: begin
        Sel_Bus_1_Mux = Sel1_size'(src);
        write         = 1'b1;
        next_state    = S_fet1;
      end

      S_br1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        next_state    = S_br2;
      end

      S_br2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        next_state    = S_fet1;
      end

      S_halt: begin
        halted     = 1'b1;
        next_state = S_halt;
      end

      default: next_state = S_idle;
    endcase
  end

endmodule

// File: tb/tb_risc_spm_control_unit.sv
`timescale 1ns/1ps
// Bench for risc_spm_control_unit: per-instruction step model compared every cycle,
// plus hand-computed literal output vectors and per-cycle invariants.
module tb_risc_spm_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted;

  risc_spm_control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
    .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {R3,R2,R1,R0, Load_PC, Inc_PC, Sel1[2:0], Sel2[1:0], Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted}
  logic [16:0] vec;
  assign vec = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
                Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted};

  logic [16:0] exp_seq [0:7];
  int          exp_n;

  function automatic logic [16:0] mk(input logic [3:0] lr, input logic lpc, input logic ipc,
                                     input logic [2:0] s1, input logic [1:0] s2, input logic lir,
                                     input logic lar, input logic ly, input logic lz,
                                     input logic wr, input logic h);
    return {lr, lpc, ipc, s1, s2, lir, lar, ly, lz, wr, h};
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if ((Load_PC && Inc_PC) || !$onehot0({Load_R0, Load_R1, Load_R2, Load_R3})) begin
        errors++;
        $display("FAIL invariant: Load_PC=%b Inc_PC=%b Load_R=%b%b%b%b expected exclusive",
                 Load_PC, Inc_PC, Load_R3, Load_R2, Load_R1, Load_R0);
      end
    end
  end

  // Expected output vector for each cycle of one instruction, starting at the first fetch step.
  task automatic build(input logic [7:0] ins, input logic z);
    logic [3:0] op;
    logic [1:0] s, d;
    logic [3:0] lr;
    op = ins[7:4];
    s  = ins[3:2];
    d  = ins[1:0];
    lr = 4'b0001 << d;
    exp_seq[0] = mk(0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
    exp_seq[1] = mk(0, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
    exp_n = 3;
    exp_seq[2] = '0;
    case (op)
      4'h0: ;
      4'h1, 4'h2, 4'h3: begin
        exp_seq[2] = mk(0, 0, 0, {1'b0, s}, 2'd1, 0, 0, 1, 0, 0, 0);
        exp_seq[3] = mk(lr, 0, 0, {1'b0, d}, 2'd0, 0, 0, 0, 1, 0, 0);
        exp_n = 4;
      end
      4'h4: exp_seq[2] = mk(lr, 0, 0, {1'b0, s}, 2'd0, 0, 0, 0, 1, 0, 0);
      4'h5, 4'h6, 4'h7, 4'h8: begin
        if (op == 4'h8 && !z) begin
          exp_seq[2] = mk(0, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        end else begin
          exp_seq[2] = mk(0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
          exp_n = 5;
          if (op == 4'h5 || op == 4'h6)
            exp_seq[3] = mk(0, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
          else
            exp_seq[3] = mk(0, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
          if (op == 4'h5)      exp_seq[4] = mk(lr, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0);
          else if (op == 4'h6) exp_seq[4] = mk(0, 0, 0, {1'b0, s}, 2'd0, 0, 0, 0, 0, 1, 0);
          else                 exp_seq[4] = mk(0, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0);
        end
      end
      default: ;
    endcase
  endtask

  // Entered at a negedge with the DUT in S_fet1; leaves it in S_fet1 (or halted).
  task automatic run_instr(input logic [7:0] ins, input logic z,
                           input int lit_step, input logic [16:0] lit_val);
    instruction = ins;
    Zflag = z;
    build(ins, z);
    for (int i = 0; i < exp_n; i++) begin
      chk($sformatf("op%h_z%0d_step%0d", ins, z, i), vec, exp_seq[i]);
      if (i == lit_step) chk($sformatf("literal_op%h_step%0d", ins, i), vec, lit_val);
      @(negedge clk);
    end
    if (ins[7:4] >= 4'h9) begin
      for (int k = 0; k < 20; k++) begin
        chk($sformatf("halt_op%h_cycle%0d", ins, k), vec, 17'h00001);
        instruction = 8'($urandom_range(0, 255));
        Zflag = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1 chk("reset_async", vec, 17'h0);
    @(negedge clk);
    chk("reset_held", vec, 17'h0);
    rst = 1'b1;
    chk("idle", vec, 17'h0);
    @(negedge clk);
    chk("fetch_after_release", vec, 17'h00450);
  endtask

  initial begin
    rst = 1'b0;
    instruction = 8'h00;
    Zflag = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", vec, 17'h0);
    rst = 1'b1;
    chk("idle", vec, 17'h0);
    @(negedge clk);
    chk("fetch_after_release", vec, 17'h00450);

    run_instr(8'h1B, 1'b0, 2, 17'h00248);
    run_instr(8'h1B, 1'b1, 3, 17'h10304);
    run_instr(8'h00, 1'b1, -1, '0);
    run_instr(8'h46, 1'b0, -1, '0);
    run_instr(8'h29, 1'b1, -1, '0);
    run_instr(8'h34, 1'b0, -1, '0);
    run_instr(8'h52, 1'b0, 4, 17'h08080);
    run_instr(8'h6C, 1'b1, 4, 17'h00302);
    run_instr(8'h70, 1'b0, -1, '0);
    run_instr(8'h80, 1'b0, 2, 17'h00800);
    run_instr(8'h80, 1'b1, 4, 17'h01080);
    run_instr(8'h4F, 1'b1, -1, '0);
    run_instr(8'h53, 1'b1, -1, '0);

    // Reset in the middle of S_ex1 must drop to idle without waiting for a clock.
    instruction = 8'h1B;
    Zflag = 1'b0;
    repeat (3) @(negedge clk);
    chk("ex1_before_reset", vec, 17'h10304);
    do_reset();

    run_instr(8'hF0, 1'b0, -1, '0);
    do_reset();
    run_instr(8'hA0, 1'b1, -1, '0);
    do_reset();
    run_instr(8'h93, 1'b0, -1, '0);
    do_reset();
    run_instr(8'h1B, 1'b0, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
